// File: rtl/latch_stim_sequencer.sv
// Registered stimulus sequencer for the latch stage: plays a fixed 13-step
// s/r/en_sr/d/en_d pattern, each step held STEP_CYCLES clocks, with start/hold/done control.
module latch_stim_sequencer #(
   parameter int STEP_CYCLES = 10,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       hold,
   output logic       s,
   output logic       r,
   output logic       en_sr,
   output logic       d,
   output logic       en_d,
   output logic [3:0] step_idx,
   output logic       busy,
   output logic       done,
   output logic       sr_illegal
);

   localparam int              EFF_CYCLES = (STEP_CYCLES < 1) ? 1 : STEP_CYCLES;
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(EFF_CYCLES - 1);
   localparam logic [3:0]       LAST_STEP = 4'd13;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       next_idx;
   logic [4:0]       next_vec;

   // Pattern as {s, r, en_sr, d, en_d}; s and r are never high together.
   function automatic logic [4:0] step_vec(input logic [3:0] idx);
      case (idx)
         4'd1:    step_vec = 5'b00000;
         4'd2:    step_vec = 5'b01000;
         4'd3:    step_vec = 5'b10000;
         4'd4:    step_vec = 5'b10100;
         4'd5:    step_vec = 5'b00100;
         4'd6:    step_vec = 5'b01100;
         4'd7:    step_vec = 5'b10100;
         4'd8:    step_vec = 5'b10100;
         4'd9:    step_vec = 5'b10100;
         4'd10:   step_vec = 5'b10101;
         4'd11:   step_vec = 5'b10110;
         4'd12:   step_vec = 5'b10111;
         4'd13:   step_vec = 5'b10111;
         default: step_vec = 5'b00000;
      endcase
   endfunction

   // step_idx is 0 in IDLE, so the same increment also selects step 1 on start.
   assign next_idx = step_idx + 4'd1;
   assign next_vec = step_vec(next_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                   <= IDLE;
         cnt                     <= '0;
         step_idx                <= 4'd0;
         {s, r, en_sr, d, en_d}  <= 5'b00000;
         busy                    <= 1'b0;
         done                    <= 1'b0;
         sr_illegal              <= 1'b0;
      end else begin
         // NOTE: done defaults low every edge so it can only ever be a one-cycle pulse.
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state                  <= RUN;
                  cnt                    <= '0;
                  step_idx               <= next_idx;
                  {s, r, en_sr, d, en_d} <= next_vec;
                  sr_illegal             <= next_vec[4] & next_vec[3];
                  busy                   <= 1'b1;
               end
            end
            RUN, PAUSE: begin
               if (hold) begin
                  state <= PAUSE;
               end else begin
                  state <= RUN;
                  if (cnt == LAST_CNT) begin
                     cnt <= '0;
                     if (step_idx == LAST_STEP) begin
                        // Outputs keep the step-13 values after completion.
                        state    <= IDLE;
                        step_idx <= 4'd0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                     end else begin
                        step_idx               <= next_idx;
                        {s, r, en_sr, d, en_d} <= next_vec;
                        sr_illegal             <= next_vec[4] & next_vec[3];
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_latch_stim_sequencer.sv
// Scoreboard bench for latch_stim_sequencer: stimulus pushes expected output events,
// a negedge monitor pops and compares them as step/done changes appear.
module tb_latch_stim_sequencer;

   typedef struct {
      int         id;
      int         cyc;
      logic [3:0] step;
      logic       done;
      logic       busy;
      logic [4:0] vec;
      int         busy_cnt;
   } ev_t;

   localparam logic [4:0] EXP_VEC [1:13] = '{
      5'b00000, 5'b01000, 5'b10000, 5'b10100, 5'b00100, 5'b01100, 5'b10100,
      5'b10100, 5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b10111};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
   logic hold_a = 1'b0, hold_off = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   illegal_cycles = 0;
   ev_t  exp_q [$];

   logic [3:0] m_step    [3];
   logic [4:0] m_vec     [3];
   logic       m_busy    [3];
   logic       m_done    [3];
   logic       m_illegal [3];
   logic [3:0] last_step [3] = '{4'd0, 4'd0, 4'd0};
   int         busy_cnt  [3] = '{0, 0, 0};

   logic s_a, r_a, esr_a, d_a, ed_a, s_b, r_b, esr_b, d_b, ed_b, s_c, r_c, esr_c, d_c, ed_c;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   latch_stim_sequencer #(.STEP_CYCLES(10), .CNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .hold(hold_a),
      .s(s_a), .r(r_a), .en_sr(esr_a), .d(d_a), .en_d(ed_a),
      .step_idx(m_step[0]), .busy(m_busy[0]), .done(m_done[0]), .sr_illegal(m_illegal[0]));

   latch_stim_sequencer #(.STEP_CYCLES(1), .CNT_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .hold(hold_off),
      .s(s_b), .r(r_b), .en_sr(esr_b), .d(d_b), .en_d(ed_b),
      .step_idx(m_step[1]), .busy(m_busy[1]), .done(m_done[1]), .sr_illegal(m_illegal[1]));

   latch_stim_sequencer #(.STEP_CYCLES(0), .CNT_W(8)) dut_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .hold(hold_off),
      .s(s_c), .r(r_c), .en_sr(esr_c), .d(d_c), .en_d(ed_c),
      .step_idx(m_step[2]), .busy(m_busy[2]), .done(m_done[2]), .sr_illegal(m_illegal[2]));

   assign m_vec[0] = {s_a, r_a, esr_a, d_a, ed_a};
   assign m_vec[1] = {s_b, r_b, esr_b, d_b, ed_b};
   assign m_vec[2] = {s_c, r_c, esr_c, d_c, ed_c};

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Advance to the start of cycle c, then settle past the edge before driving.
   task automatic wait_cycle(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input int id, input int c);
      wait_cycle(c);
      case (id)
         0: start_a = 1'b1;
         1: start_b = 1'b1;
         default: start_c = 1'b1;
      endcase
      wait_cycle(c + 1);
      start_a = 1'b0;
      start_b = 1'b0;
      start_c = 1'b0;
   endtask

   // Expected events for a run whose start is sampled at the end of cycle t0.
   // Steps after hold_step are delayed by hold_len frozen cycles.
   task automatic push_run(input int id, input int t0, input int sc, input int hold_step,
                           input int hold_len, input int last, input bit with_done);
      ev_t e;
      for (int n = 1; n <= last; n++) begin
         e.id = id;
         e.cyc = t0 + 1 + (n - 1) * sc + ((n > hold_step) ? hold_len : 0);
         e.step = 4'(n);
         e.done = 1'b0;
         e.busy = 1'b1;
         e.vec = EXP_VEC[n];
         e.busy_cnt = -1;
         exp_q.push_back(e);
      end
      if (with_done) begin
         e.id = id;
         e.cyc = t0 + 1 + 13 * sc + hold_len;
         e.step = 4'd0;
         e.done = 1'b1;
         e.busy = 1'b0;
         e.vec = EXP_VEC[13];
         e.busy_cnt = 13 * sc + hold_len;
         exp_q.push_back(e);
      end
   endtask

   // Monitor: any step change or done pulse is an output event to be scored.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (m_illegal[i]) illegal_cycles++;
         if (m_step[i] != last_step[i] || m_done[i]) begin
            if (exp_q.size() == 0) begin
               check($sformatf("unexpected_event_dut%0d_step", i), int'(m_step[i]), -1);
            end else begin
               ev_t e;
               e = exp_q.pop_front();
               check("ev_dut", i, e.id);
               check("ev_cycle", cyc, e.cyc);
               check("ev_step_idx", int'(m_step[i]), int'(e.step));
               check("ev_done", int'(m_done[i]), int'(e.done));
               check("ev_busy", int'(m_busy[i]), int'(e.busy));
               check("ev_outputs", int'(m_vec[i]), int'(e.vec));
               if (e.busy_cnt >= 0) check("ev_busy_cycles", busy_cnt[i], e.busy_cnt);
            end
            if (m_step[i] == 4'd0) busy_cnt[i] = 0;
         end
         if (m_busy[i]) busy_cnt[i]++;
         last_step[i] = m_step[i];
      end
   end

   initial begin
      ev_t e;
      wait_cycle(5);
      rst_n = 1'b1;

      // Idle after reset: everything stays at zero with start low.
      for (int c = 6; c < 26; c++) begin
         wait_cycle(c);
         @(negedge clk);
         for (int i = 0; i < 3; i++)
            check($sformatf("reset_idle_dut%0d", i),
                  int'({m_step[i], m_busy[i], m_done[i], m_vec[i], m_illegal[i]}), 0);
      end

      // Plain run with start re-pulsed mid-run and on the last busy cycle.
      push_run(0, 30, 10, 13, 0, 13, 1'b1);
      pulse(0, 30);
      pulse(0, 80);
      pulse(0, 160);

      // Hold for 7 cycles while step 6 is active (step 6 spans cycles 221..230).
      push_run(0, 170, 10, 6, 7, 13, 1'b1);
      pulse(0, 170);
      wait_cycle(223);
      hold_a = 1'b1;
      wait_cycle(230);
      hold_a = 1'b0;

      // Reset during step 8 aborts without done; a fresh run follows.
      push_run(0, 320, 10, 13, 0, 8, 1'b0);
      e.id = 0; e.cyc = 395; e.step = 4'd0; e.done = 1'b0; e.busy = 1'b0;
      e.vec = 5'b00000; e.busy_cnt = -1;
      exp_q.push_back(e);
      pulse(0, 320);
      wait_cycle(395);
      rst_n = 1'b0;
      wait_cycle(397);
      rst_n = 1'b1;
      push_run(0, 400, 10, 13, 0, 13, 1'b1);
      pulse(0, 400);

      // STEP_CYCLES=1 and STEP_CYCLES=0 both advance every clock.
      wait_cycle(540);
      push_run(1, 540, 1, 13, 0, 13, 1'b1);
      pulse(1, 540);
      wait_cycle(560);
      push_run(2, 560, 1, 13, 0, 13, 1'b1);
      pulse(2, 560);

      wait_cycle(590);
      @(negedge clk);
      #1;
      check("pending_events", exp_q.size(), 0);
      check("sr_illegal_cycles", illegal_cycles, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
